// File: rtl/branch_resolve_unit_if.sv
// Fetch/execute/BHT-write bundle for branch_resolve_unit.
// Handshake: a prediction transfers on a rising clk edge where pred_valid & pred_ready are both 1. res_valid has no ready and is a one-cycle resolve strobe for the oldest entry.
interface branch_resolve_unit_if #(
   parameter int IDX_W = 5,
   parameter int PC_W  = 32
);
   logic             pred_valid;
   logic [PC_W-1:0]  pred_pc;
   logic [IDX_W-1:0] pred_idx;
   logic             pred_taken;
   logic [PC_W-1:0]  pred_target;
   logic             pred_ready;
   logic             res_valid;
   logic             res_taken;
   logic [PC_W-1:0]  res_target;
   logic             upd_en;
   logic [IDX_W-1:0] upd_idx;
   logic             upd_taken;
   logic             flush;
   logic [PC_W-1:0]  redirect_pc;
   logic             err_underflow;

   modport master (
      output pred_valid, pred_pc, pred_idx, pred_taken, pred_target,
      output res_valid, res_taken, res_target,
      input  pred_ready, upd_en, upd_idx, upd_taken, flush, redirect_pc, err_underflow
   );

   modport slave (
      input  pred_valid, pred_pc, pred_idx, pred_taken, pred_target,
      input  res_valid, res_taken, res_target,
      output pred_ready, upd_en, upd_idx, upd_taken, flush, redirect_pc, err_underflow
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// In-order FIFO of in-flight branch predictions; emits BHT training writes and mispredict flush/redirect.
// Optional BRU_STATS_EN adds saturating br_count/mp_count outputs.
module branch_resolve_unit #(
   parameter int DEPTH = 4,
   parameter int IDX_W = 5,
   parameter int PC_W  = 32
) (
   input logic clk,
   input logic arst_n,
   branch_resolve_unit_if.slave bus
`ifdef BRU_STATS_EN
   ,
   output logic [15:0] br_count,
   output logic [15:0] mp_count
`endif
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [PC_W-1:0]  pc_mem     [DEPTH];
   logic [IDX_W-1:0] idx_mem    [DEPTH];
   logic             taken_mem  [DEPTH];
   logic [PC_W-1:0]  target_mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   logic             full;
   logic             push;
   logic             pop;
   logic             mispredict;
   logic             underflow;
   logic [PC_W-1:0]  head_pc;
   logic [IDX_W-1:0] head_idx;
   logic             head_taken;
   logic [PC_W-1:0]  head_target;

   always_comb begin
      full           = (count == CNT_W'(DEPTH));
      bus.pred_ready = ~full & ~bus.flush;
      push           = bus.pred_valid & bus.pred_ready;
      head_pc        = pc_mem[rd_ptr];
      head_idx       = idx_mem[rd_ptr];
      head_taken     = taken_mem[rd_ptr];
      head_target    = target_mem[rd_ptr];
      // Resolutions are ignored during the flush cycle; an empty FIFO is an underflow.
      pop            = bus.res_valid & ~bus.flush & (count != '0);
      underflow      = bus.res_valid & ~bus.flush & (count == '0);
      mispredict     = pop & ((bus.res_taken != head_taken) |
                              (bus.res_taken & head_taken & (bus.res_target != head_target)));
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]     <= bus.pred_pc;
         idx_mem[wr_ptr]    <= bus.pred_idx;
         taken_mem[wr_ptr]  <= bus.pred_taken;
         target_mem[wr_ptr] <= bus.pred_target;
      end
   end

   // A mispredict clears the FIFO and drops any push from the same cycle.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (mispredict) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         bus.upd_en        <= 1'b0;
         bus.upd_idx       <= '0;
         bus.upd_taken     <= 1'b0;
         bus.flush         <= 1'b0;
         bus.redirect_pc   <= '0;
         bus.err_underflow <= 1'b0;
      end else begin
         bus.upd_en <= pop;
         bus.flush  <= mispredict;
         if (pop) begin
            bus.upd_idx   <= head_idx;
            bus.upd_taken <= bus.res_taken;
         end
         if (mispredict)
            bus.redirect_pc <= bus.res_taken ? bus.res_target : head_pc + PC_W'(4);
         if (underflow)
            bus.err_underflow <= 1'b1;
      end
   end

`ifdef BRU_STATS_EN
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         br_count <= '0;
         mp_count <= '0;
      end else begin
         if (pop && br_count != 16'hFFFF)        br_count <= br_count + 16'd1;
         if (mispredict && mp_count != 16'hFFFF) mp_count <= mp_count + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: resolve, mispredict, full/wrap, flush, underflow, async reset.
module tb_branch_resolve_unit;
   localparam int IDX_W = 5;
   localparam int PC_W  = 32;

   logic clk;
   logic arst_n;
   int   tests_run;
   int   failures;
   logic [IDX_W-1:0] exp_q[$];
   logic [IDX_W-1:0] exp_idx;

   branch_resolve_unit_if #(.IDX_W(IDX_W), .PC_W(PC_W)) bus ();

   branch_resolve_unit #(.DEPTH(4), .IDX_W(IDX_W), .PC_W(PC_W)) dut (
      .clk    (clk),
      .arst_n (arst_n),
      .bus    (bus.slave)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- driver tasks (entered and left at posedge+1) ----------------
   task automatic idle_cycle();
      bus.pred_valid = 1'b0;
      bus.res_valid  = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic do_push(input logic [31:0] pc, input logic [4:0] idx,
                          input logic tk, input logic [31:0] tgt);
      bus.pred_valid  = 1'b1;
      bus.pred_pc     = pc;
      bus.pred_idx    = idx;
      bus.pred_taken  = tk;
      bus.pred_target = tgt;
      @(posedge clk); #1;
      bus.pred_valid  = 1'b0;
   endtask

   task automatic do_resolve(input logic tk, input logic [31:0] tgt);
      bus.res_valid  = 1'b1;
      bus.res_taken  = tk;
      bus.res_target = tgt;
      @(posedge clk); #1;
      bus.res_valid  = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      arst_n = 1'b0;
      bus.pred_valid = 0; bus.pred_pc = 0; bus.pred_idx = 0; bus.pred_taken = 0; bus.pred_target = 0;
      bus.res_valid = 0; bus.res_taken = 0; bus.res_target = 0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++; if (bus.upd_en !== 1'b0) begin failures++; $display("FAIL reset_upd_en got %b exp 0", bus.upd_en); end
      tests_run++; if (bus.upd_idx !== 5'd0) begin failures++; $display("FAIL reset_upd_idx got %0d exp 0", bus.upd_idx); end
      tests_run++; if (bus.upd_taken !== 1'b0) begin failures++; $display("FAIL reset_upd_taken got %b exp 0", bus.upd_taken); end
      tests_run++; if (bus.flush !== 1'b0) begin failures++; $display("FAIL reset_flush got %b exp 0", bus.flush); end
      tests_run++; if (bus.redirect_pc !== 32'h0) begin failures++; $display("FAIL reset_redirect got %h exp 0", bus.redirect_pc); end
      tests_run++; if (bus.err_underflow !== 1'b0) begin failures++; $display("FAIL reset_err got %b exp 0", bus.err_underflow); end
      tests_run++; if (bus.pred_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b exp 1", bus.pred_ready); end
      arst_n = 1'b1;
      idle_cycle();
   endtask

   task automatic test_correct_resolve();
      do_push(32'h40, 5'd16, 1'b0, 32'h0);
      do_resolve(1'b0, 32'h0);
      tests_run++; if (bus.upd_en !== 1'b1) begin failures++; $display("FAIL correct_upd_en got %b exp 1", bus.upd_en); end
      tests_run++; if (bus.upd_idx !== 5'd16) begin failures++; $display("FAIL correct_upd_idx got %0d exp 16", bus.upd_idx); end
      tests_run++; if (bus.upd_taken !== 1'b0) begin failures++; $display("FAIL correct_upd_taken got %b exp 0", bus.upd_taken); end
      tests_run++; if (bus.flush !== 1'b0) begin failures++; $display("FAIL correct_flush got %b exp 0", bus.flush); end
      idle_cycle();
      tests_run++; if (bus.upd_en !== 1'b0) begin failures++; $display("FAIL correct_strobe_len got %b exp 0", bus.upd_en); end
      tests_run++; if (dut.count !== 3'd0) begin failures++; $display("FAIL correct_count got %0d exp 0", dut.count); end
   endtask

   task automatic test_mispredict_dir();
      do_push(32'h80, 5'd3, 1'b0, 32'h0);
      do_resolve(1'b1, 32'h200);
      tests_run++; if (bus.flush !== 1'b1) begin failures++; $display("FAIL dir_flush got %b exp 1", bus.flush); end
      tests_run++; if (bus.redirect_pc !== 32'h200) begin failures++; $display("FAIL dir_redirect got %h exp 200", bus.redirect_pc); end
      tests_run++; if (dut.count !== 3'd0) begin failures++; $display("FAIL dir_count got %0d exp 0", dut.count); end
      tests_run++; if (bus.pred_ready !== 1'b0) begin failures++; $display("FAIL dir_ready got %b exp 0", bus.pred_ready); end
      tests_run++; if (bus.upd_en !== 1'b1 || bus.upd_idx !== 5'd3 || bus.upd_taken !== 1'b1) begin
         failures++; $display("FAIL dir_update got en=%b idx=%0d tk=%b exp en=1 idx=3 tk=1", bus.upd_en, bus.upd_idx, bus.upd_taken); end
      idle_cycle();
      tests_run++; if (bus.flush !== 1'b0) begin failures++; $display("FAIL dir_flush_len got %b exp 0", bus.flush); end
      tests_run++; if (bus.redirect_pc !== 32'h200) begin failures++; $display("FAIL dir_redirect_hold got %h exp 200", bus.redirect_pc); end
      tests_run++; if (bus.pred_ready !== 1'b1) begin failures++; $display("FAIL dir_ready_back got %b exp 1", bus.pred_ready); end
   endtask

   task automatic test_mispredict_target();
      do_push(32'h100, 5'd5, 1'b1, 32'h300);
      do_resolve(1'b1, 32'h340);
      tests_run++; if (bus.flush !== 1'b1 || bus.redirect_pc !== 32'h340) begin
         failures++; $display("FAIL tgt_redirect got flush=%b pc=%h exp flush=1 pc=340", bus.flush, bus.redirect_pc); end
      idle_cycle();
      do_push(32'h100, 5'd5, 1'b1, 32'h300);
      do_resolve(1'b0, 32'h0);
      tests_run++; if (bus.flush !== 1'b1 || bus.redirect_pc !== 32'h104) begin
         failures++; $display("FAIL tgt_fallthru got flush=%b pc=%h exp flush=1 pc=104", bus.flush, bus.redirect_pc); end
      idle_cycle();
      do_push(32'h100, 5'd5, 1'b1, 32'h300);
      do_resolve(1'b1, 32'h300);
      tests_run++; if (bus.flush !== 1'b0 || bus.upd_en !== 1'b1 || bus.upd_taken !== 1'b1) begin
         failures++; $display("FAIL tgt_correct got flush=%b en=%b tk=%b exp 0 1 1", bus.flush, bus.upd_en, bus.upd_taken); end
      idle_cycle();
   endtask

   task automatic test_flush_discard();
      do_push(32'h500, 5'd7, 1'b0, 32'h0);
      bus.pred_valid = 1'b1; bus.pred_idx = 5'd8; bus.pred_pc = 32'h504; bus.pred_taken = 1'b0;
      bus.res_valid = 1'b1; bus.res_taken = 1'b1; bus.res_target = 32'h500;
      @(posedge clk); #1;
      tests_run++; if (bus.flush !== 1'b1 || dut.count !== 3'd0) begin
         failures++; $display("FAIL discard_same_cycle got flush=%b count=%0d exp 1 0", bus.flush, dut.count); end
      bus.pred_idx = 5'd9; bus.res_taken = 1'b0;
      @(posedge clk); #1;
      bus.pred_valid = 1'b0; bus.res_valid = 1'b0;
      tests_run++; if (dut.count !== 3'd0) begin failures++; $display("FAIL discard_flush_push got count=%0d exp 0", dut.count); end
      tests_run++; if (bus.upd_en !== 1'b0 || bus.flush !== 1'b0 || bus.err_underflow !== 1'b0) begin
         failures++; $display("FAIL discard_flush_res got en=%b flush=%b err=%b exp 0 0 0", bus.upd_en, bus.flush, bus.err_underflow); end
   endtask

   task automatic test_back_to_back();
      do_push(32'h600, 5'd10, 1'b0, 32'h0);
      bus.pred_valid = 1'b1; bus.pred_pc = 32'h604; bus.pred_idx = 5'd11; bus.pred_taken = 1'b0;
      bus.res_valid = 1'b1; bus.res_taken = 1'b0;
      @(posedge clk); #1;
      bus.pred_valid = 1'b0;
      tests_run++; if (bus.upd_idx !== 5'd10 || dut.count !== 3'd1) begin
         failures++; $display("FAIL b2b_simul got idx=%0d count=%0d exp 10 1", bus.upd_idx, dut.count); end
      @(posedge clk); #1;
      bus.res_valid = 1'b0;
      tests_run++; if (bus.upd_en !== 1'b1 || bus.upd_idx !== 5'd11 || dut.count !== 3'd0) begin
         failures++; $display("FAIL b2b_second got en=%b idx=%0d count=%0d exp 1 11 0", bus.upd_en, bus.upd_idx, dut.count); end
      idle_cycle();
   endtask

   task automatic test_full_wrap();
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 4; i++) begin
            do_push(32'h1000 + 32'(r * 16 + i * 4), 5'(20 + r * 4 + i), 1'b0, 32'h0);
            exp_q.push_back(5'(20 + r * 4 + i));
         end
         tests_run++; if (bus.pred_ready !== 1'b0 || dut.count !== 3'd4) begin
            failures++; $display("FAIL wrap_full r%0d got ready=%b count=%0d exp 0 4", r, bus.pred_ready, dut.count); end
         do_push(32'hDEAD, 5'd0, 1'b0, 32'h0);
         tests_run++; if (dut.count !== 3'd4) begin failures++; $display("FAIL wrap_fifth r%0d got count=%0d exp 4", r, dut.count); end
         do_resolve(1'b0, 32'h0);
         exp_idx = exp_q.pop_front();
         tests_run++; if (bus.upd_en !== 1'b1 || bus.upd_idx !== exp_idx || bus.pred_ready !== 1'b1) begin
            failures++; $display("FAIL wrap_first r%0d got en=%b idx=%0d ready=%b exp 1 %0d 1", r, bus.upd_en, bus.upd_idx, bus.pred_ready, exp_idx); end
         bus.res_valid = 1'b1; bus.res_taken = 1'b0;
         for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            exp_idx = exp_q.pop_front();
            tests_run++; if (bus.upd_en !== 1'b1 || bus.upd_idx !== exp_idx) begin
               failures++; $display("FAIL wrap_drain r%0d k%0d got en=%b idx=%0d exp 1 %0d", r, k, bus.upd_en, bus.upd_idx, exp_idx); end
         end
         idle_cycle();
         tests_run++; if (dut.count !== 3'd0 || bus.upd_en !== 1'b0) begin
            failures++; $display("FAIL wrap_empty r%0d got count=%0d en=%b exp 0 0", r, dut.count, bus.upd_en); end
      end
   endtask

   task automatic test_underflow();
      tests_run++; if (bus.err_underflow !== 1'b0) begin failures++; $display("FAIL uf_pre got %b exp 0", bus.err_underflow); end
      do_resolve(1'b1, 32'h40);
      tests_run++; if (bus.upd_en !== 1'b0 || bus.flush !== 1'b0 || bus.err_underflow !== 1'b1) begin
         failures++; $display("FAIL uf_set got en=%b flush=%b err=%b exp 0 0 1", bus.upd_en, bus.flush, bus.err_underflow); end
      repeat (3) idle_cycle();
      tests_run++; if (bus.err_underflow !== 1'b1) begin failures++; $display("FAIL uf_sticky got %b exp 1", bus.err_underflow); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) do_push(32'h2000 + 32'(i * 4), 5'(1 + i), 1'b0, 32'h0);
      do_resolve(1'b0, 32'h0);
      tests_run++; if (bus.upd_en !== 1'b1 || bus.upd_idx !== 5'd1 || dut.count !== 3'd3) begin
         failures++; $display("FAIL rst_pre got en=%b idx=%0d count=%0d exp 1 1 3", bus.upd_en, bus.upd_idx, dut.count); end
      bus.res_valid = 1'b1; bus.res_taken = 1'b1; bus.res_target = 32'h900;
      #2 arst_n = 1'b0;
      #1;
      tests_run++; if (bus.upd_en !== 1'b0 || bus.upd_idx !== 5'd0 || bus.upd_taken !== 1'b0) begin
         failures++; $display("FAIL rst_upd got en=%b idx=%0d tk=%b exp 0 0 0", bus.upd_en, bus.upd_idx, bus.upd_taken); end
      tests_run++; if (bus.flush !== 1'b0 || bus.redirect_pc !== 32'h0 || bus.err_underflow !== 1'b0) begin
         failures++; $display("FAIL rst_outs got flush=%b pc=%h err=%b exp 0 0 0", bus.flush, bus.redirect_pc, bus.err_underflow); end
      tests_run++; if (dut.count !== 3'd0 || bus.pred_ready !== 1'b1) begin
         failures++; $display("FAIL rst_fifo got count=%0d ready=%b exp 0 1", dut.count, bus.pred_ready); end
      @(posedge clk); #1;
      bus.res_valid = 1'b0;
      arst_n = 1'b1;
      idle_cycle();
      tests_run++; if (bus.flush !== 1'b0 || dut.count !== 3'd0) begin
         failures++; $display("FAIL rst_after got flush=%b count=%0d exp 0 0", bus.flush, dut.count); end
      do_push(32'h3000, 5'd30, 1'b1, 32'h3100);
      do_resolve(1'b1, 32'h3100);
      tests_run++; if (bus.upd_en !== 1'b1 || bus.upd_idx !== 5'd30 || bus.flush !== 1'b0) begin
         failures++; $display("FAIL rst_alive got en=%b idx=%0d flush=%b exp 1 30 0", bus.upd_en, bus.upd_idx, bus.flush); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      tests_run = 0;
      failures  = 0;
      test_reset();
      test_correct_resolve();
      test_mispredict_dir();
      test_mispredict_target();
      test_flush_discard();
      test_back_to_back();
      test_full_wrap();
      test_underflow();
      test_reset_mid();
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Tracks every branch prediction issued at fetch until the execute stage resolves it, then produces the 2-bit BHT training write and the pipeline flush/redirect on a misprediction. Sits between fetch (prediction producer), execute (outcome producer) and the branch history table's write side (en/write_addr/was_taken). Holds in-flight predictions in a small in-order FIFO.

## Interface
- DEPTH, 4: in-flight branch entries (power of two, 2..16)
- IDX_W, 5: BHT index width
- PC_W, 32: program counter width

- clk  input  1  rising-edge clock
- arst_n  input  1  asynchronous active-low reset
- pred_valid  input  1  fetch issues a predicted branch this cycle
- pred_pc  input  PC_W  PC of the branch
- pred_idx  input  IDX_W  BHT index used for the prediction
- pred_taken  input  1  predicted direction
- pred_target  input  PC_W  predicted target (meaningful when pred_taken=1)
- pred_ready  output  1  FIFO can accept; push = pred_valid & pred_ready
- res_valid  input  1  execute resolves the oldest in-flight branch
- res_taken  input  1  actual direction
- res_target  input  PC_W  actual taken target
- upd_en  output  1  one-cycle BHT write strobe
- upd_idx  output  IDX_W  BHT write index
- upd_taken  output  1  actual outcome for BHT training
- flush  output  1  one-cycle misprediction flush
- redirect_pc  output  PC_W  correct fetch PC, valid while flush=1
- err_underflow  output  1  sticky: res_valid seen with FIFO empty

## Operation
- FIFO of {pc, idx, taken, target}, DEPTH entries, wr/rd pointers wrap modulo DEPTH, count 0..DEPTH.
- pred_ready = (count != DEPTH) & ~flush.
- Resolution (res_valid=1, count>0): pop head; next cycle upd_en=1, upd_idx=head.idx, upd_taken=res_taken.
- Mispredict = (res_taken != head.taken) | (res_taken & head.taken & res_target != head.target).
- On mispredict: next cycle flush=1, redirect_pc = res_taken ? res_target : head.pc + 4 (mod 2^PC_W); FIFO cleared (count=0, pointers reset) at the sampling edge; a same-cycle push is discarded.
- While flush=1: pred_ready=0, pushes ignored, res_valid ignored.
- res_valid with count=0: no update, no flush, err_underflow set until reset.
- Simultaneous push and correct resolution: both take effect, count unchanged.
- upd_en, flush, redirect_pc are registered; redirect_pc holds its last value when flush=0.

## Timing
- Reset: upd_en=0, upd_idx=0, upd_taken=0, flush=0, redirect_pc=0, err_underflow=0, count=0, pred_ready=1.
- Push visible to resolution from the next cycle (no same-cycle push/pop bypass when empty).
- Resolution to upd_en/flush: 1 cycle; each strobe exactly 1 cycle per resolution.
- Back-to-back correct resolutions: upd_en high on consecutive cycles.
- Reset mid-operation clears FIFO and all outputs asynchronously.

## Configuration
- BRU_STATS_EN defined: adds outputs br_count and mp_count (16 bits each, saturating at 16'hFFFF), incremented on every accepted resolution and every mispredict respectively; reset to 0.
- Undefined: ports and counters absent; other behaviour identical.

## Test plan
- Push {pc=0x40, idx=16, taken=0}; resolve res_taken=0 -> next cycle upd_en=1, upd_idx=16, upd_taken=0, flush=0.
- Push {pc=0x80, taken=0}; resolve res_taken=1, res_target=0x200 -> flush=1, redirect_pc=0x200, count=0, pred_ready=0 that cycle.
- Push {pc=0x100, taken=1, target=0x300}; resolve res_taken=1, res_target=0x340 -> flush=1, redirect_pc=0x340; res_taken=0 instead -> redirect_pc=0x104.
- Push 4 entries with no resolution -> pred_ready=0; fifth pred_valid ignored; resolve one correctly -> pred_ready=1; wrap pointers over 3 fill/drain rounds, order preserved.
- res_valid with empty FIFO -> no upd_en, no flush, err_underflow=1 until arst_n low.
- Assert arst_n low with 3 entries in flight and flush pending -> all outputs reset, count=0, pred_ready=1; with BRU_STATS_EN, br_count/mp_count return to 0.
